// File: rtl/dpram_access_ctrl_if.sv
// Client-side bus of the 16x8 dual-port RAM front-end.
// Carries the write request, read request and read response handshakes.
//   master : client side (drives requests, consumes responses)
//   slave  : controller side (accepts requests, produces responses)
// Signals: wr_valid/wr_ready/wr_addr/wr_data, rd_valid/rd_ready/rd_addr,
//          rsp_valid/rsp_ready/rsp_data/rsp_err.
interface dpram_access_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready,
    input  wr_ready, rd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready,
    output wr_ready, rd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/dpram_access_ctrl.sv
// Request front-end placed directly upstream of the 16x8 dual-port RAM.
// Accepts write/read requests, range-checks addresses, drives the RAM pins
// and captures the RAM's registered read data into a one-entry response
// buffer so that clients never see the RAM latency.
// Ports:
//   clk, rst      single rising-edge clock, asynchronous active-high reset
//   bus           client handshakes (dpram_access_ctrl_if.slave)
//   err_cnt       count of out-of-range requests, saturates at 255
//   ram_enb/wr/rd, ram_w_addr, ram_r_addr, ram_w_data -> RAM pins
//   ram_r_data    <- RAM read data, valid the cycle after ram_rd
// Optional feature: define DPRAM_WR_BYPASS_EN to return the written data for a
// same-cycle, same-address in-range write and read (default: old RAM data).
module dpram_access_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  dpram_access_ctrl_if.slave bus,
  output logic [7:0]        err_cnt,
  output logic              ram_enb,
  output logic              ram_wr,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic [ADDR_W-1:0] ram_r_addr,
  output logic [DATA_W-1:0] ram_w_data,
  input  logic [DATA_W-1:0] ram_r_data
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic              wr_rdy;
  logic              rd_rdy;
  logic              wr_fire;
  logic              rd_fire;
  logic              wr_in;
  logic              rd_in;
  logic              wr_bad;
  logic              rd_bad;
  logic [1:0]        bad_n;
  logic [8:0]        err_sum;

  logic              rd_pend;
  logic              rd_err;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic [DATA_W-1:0] rd_data_sel;

`ifdef DPRAM_WR_BYPASS_EN
  logic              byp_hit;
  logic [DATA_W-1:0] byp_data;
`endif

  // Handshake readiness is gated by rst so that every output reads 0 while
  // the block is held in reset.
  assign wr_rdy  = !rst;
  assign rd_rdy  = !rst && !rd_pend && (!rsp_valid || bus.rsp_ready);
  assign wr_fire = bus.wr_valid && wr_rdy;
  assign rd_fire = bus.rd_valid && rd_rdy;
  assign wr_in   = {1'b0, bus.wr_addr} < DEPTH_L;
  assign rd_in   = {1'b0, bus.rd_addr} < DEPTH_L;
  assign wr_bad  = wr_fire && !wr_in;
  assign rd_bad  = rd_fire && !rd_in;
  assign bad_n   = {1'b0, wr_bad} + {1'b0, rd_bad};
  assign err_sum = {1'b0, err_cnt} + {7'b0, bad_n};

  assign bus.wr_ready  = wr_rdy;
  assign bus.rd_ready  = rd_rdy;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
  assign bus.rsp_err   = rsp_err;

  always_comb begin
    ram_wr     = 1'b0;
    ram_rd     = 1'b0;
    ram_w_addr = '0;
    ram_r_addr = '0;
    ram_w_data = '0;
    if (wr_fire && wr_in) begin
      ram_wr     = 1'b1;
      ram_w_addr = bus.wr_addr;
      ram_w_data = bus.wr_data;
    end
    if (rd_fire && rd_in) begin
      ram_rd     = 1'b1;
      ram_r_addr = bus.rd_addr;
    end
    ram_enb = ram_wr | ram_rd;
  end

  // Data loaded into the response buffer one edge after acceptance.
  always_comb begin
    rd_data_sel = ram_r_data;
`ifdef DPRAM_WR_BYPASS_EN
    if (byp_hit) rd_data_sel = byp_data;
`endif
    if (rd_err) rd_data_sel = '0;
  end

`ifdef DPRAM_WR_BYPASS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else if (rd_fire) begin
      byp_hit  <= ram_wr && ram_rd && (bus.wr_addr == bus.rd_addr);
      byp_data <= bus.wr_data;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt   <= '0;
      rd_pend   <= 1'b0;
      rd_err    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      err_cnt <= (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
      rd_pend <= rd_fire;
      if (rd_fire) rd_err <= !rd_in;
      // rd_ready guarantees the buffer is empty (or draining) when a read is
      // accepted, so a pending load never overwrites an unconsumed response.
      if (rd_pend) begin
        rsp_valid <= 1'b1;
        rsp_data  <= rd_data_sel;
        rsp_err   <= rd_err;
      end else if (rsp_valid && bus.rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dpram_access_ctrl.sv
module tb_dpram_access_ctrl;

`ifdef DPRAM_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] err_cnt;
  logic       ram_enb, ram_wr, ram_rd;
  logic [4:0] ram_w_addr, ram_r_addr;
  logic [7:0] ram_w_data;
  logic [7:0] ram_r_data = 8'h00;
  logic [7:0] ram_mem [16] = '{default: 8'h00};

  dpram_access_ctrl_if #(.ADDR_W(5), .DATA_W(8)) bus ();

  dpram_access_ctrl #(.ADDR_W(5), .DATA_W(8), .DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .err_cnt    (err_cnt),
    .ram_enb    (ram_enb),
    .ram_wr     (ram_wr),
    .ram_rd     (ram_rd),
    .ram_w_addr (ram_w_addr),
    .ram_r_addr (ram_r_addr),
    .ram_w_data (ram_w_data),
    .ram_r_data (ram_r_data)
  );

  always #5 clk = ~clk;

  // 16x8 dual-port RAM with registered read (read-before-write on collision).
  always @(posedge clk) begin
    if (ram_wr) ram_mem[ram_w_addr[3:0]] <= ram_w_data;
    if (ram_rd) ram_r_data <= ram_mem[ram_r_addr[3:0]];
  end

  // Reference model: expected memory image, ordered response queue with the
  // cycle each response becomes visible, and the error tally.
  typedef struct {
    logic        err;
    logic [7:0]  data;
    int unsigned at;
  } rsp_t;

  logic [7:0]  mem [16] = '{default: 8'h00};
  rsp_t        q [$];
  int unsigned cyc = 0;
  int unsigned errs = 0;
  bit          rd_hold = 1'b0;
  bit          last_rf = 1'b0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic wv, input logic [4:0] wa, input logic [7:0] wd,
                      input logic rv, input logic [4:0] ra, input logic rr);
    bit         vis, e_rdy, rf, take, wbad, rbad, ewr, erd;
    rsp_t       r;
    @(negedge clk);
    bus.wr_valid  = wv;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    bus.rd_valid  = rv;
    bus.rd_addr   = ra;
    bus.rsp_ready = rr;
    #1;
    vis   = (q.size() > 0) && (q[0].at <= cyc);
    e_rdy = (q.size() == 0) || ((q.size() == 1) && vis && rr);
    rf    = rv && e_rdy;
    wbad  = wv && (wa >= 5'd16);
    rbad  = rf && (ra >= 5'd16);
    ewr   = wv && !wbad;
    erd   = rf && !rbad;
    chk("wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("rd_ready", 32'(bus.rd_ready), 32'(e_rdy));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(vis));
    if (vis) begin
      chk("rsp_data", 32'(bus.rsp_data), 32'(q[0].data));
      chk("rsp_err", 32'(bus.rsp_err), 32'(q[0].err));
    end
    chk("err_cnt", 32'(err_cnt), errs);
    chk("ram_pins", 32'({ram_enb, ram_wr, ram_rd, ram_w_addr, ram_r_addr, ram_w_data}),
        32'({ewr || erd, ewr, erd, ewr ? wa : 5'd0, erd ? ra : 5'd0, ewr ? wd : 8'd0}));
    take = vis && rr;
    cyc++;
    if (take) void'(q.pop_front());
    if (rf) begin
      r.err  = rbad;
      if (rbad)                          r.data = 8'h00;
      else if (BYP && ewr && (wa == ra)) r.data = wd;
      else                               r.data = mem[ra[3:0]];
      r.at = cyc + 1;
      q.push_back(r);
    end
    if (ewr) mem[wa[3:0]] = wd;
    errs = errs + int'(wbad) + int'(rbad);
    if (errs > 255) errs = 255;
    rd_hold = rv && !rf;
    last_rf = rf;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 5'd0, 8'd0, 1'b0, 5'd0, 1'b1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("rst_rd_ready", 32'(bus.rd_ready), 32'd0);
    chk("rst_rsp", 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_data}), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_ram_pins", 32'({ram_enb, ram_wr, ram_rd, ram_w_addr, ram_r_addr, ram_w_data}), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.delete();
    errs    = 0;
    rd_hold = 1'b0;
  endtask

  function automatic logic [4:0] rand_addr();
    return ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 15)) : 5'($urandom_range(16, 31));
  endfunction

  initial begin
    logic [4:0] ra;
    logic       rv;
    int unsigned k;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_valid = 1'b0; bus.rd_addr = '0; bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Write then read back.
    step(1'b1, 5'd3, 8'h5A, 1'b0, 5'd0, 1'b1);
    step(1'b0, 5'd0, 8'h00, 1'b1, 5'd3, 1'b1);
    idle(3);

    // Out-of-range read and write.
    step(1'b0, 5'd0, 8'h00, 1'b1, 5'd20, 1'b1);
    idle(3);
    step(1'b1, 5'd31, 8'hAB, 1'b0, 5'd0, 1'b1);
    idle(1);

    // Same-cycle write and read to one address.
    step(1'b1, 5'd7, 8'h11, 1'b0, 5'd0, 1'b1);
    step(1'b1, 5'd7, 8'h22, 1'b1, 5'd7, 1'b1);
    idle(3);
    step(1'b0, 5'd0, 8'h00, 1'b1, 5'd7, 1'b1);
    idle(3);

    // Back-pressure: hold a response for 10 cycles, then drain in order.
    step(1'b1, 5'd5, 8'h55, 1'b1, 5'd3, 1'b0);
    step(1'b1, 5'd6, 8'h66, 1'b0, 5'd0, 1'b0);
    for (int unsigned i = 0; i < 10; i++) step(1'b0, 5'd0, 8'h00, 1'b1, 5'd5, 1'b0);
    k = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      step(1'b0, 5'd0, 8'h00, 1'b1, 5'(5 + k), 1'b1);
      if (last_rf) k++;
    end
    idle(3);

    // Reset in the middle of a read.
    step(1'b1, 5'd9, 8'h99, 1'b1, 5'd5, 1'b1);
    do_reset();
    idle(4);

    // Randomized traffic.
    for (int unsigned i = 0; i < 2000; i++) begin
      if (rd_hold) begin
        rv = 1'b1;
        ra = bus.rd_addr;
      end else begin
        rv = 1'($urandom_range(0, 1));
        ra = rand_addr();
      end
      step(1'($urandom_range(0, 1)), rand_addr(), 8'($urandom), rv, ra,
           1'($urandom_range(0, 9) < 7));
    end
    idle(3);

    // Error counter saturation.
    for (int unsigned i = 0; i < 300; i++)
      step(1'b1, 5'($urandom_range(16, 31)), 8'($urandom), 1'b0, 5'd0, 1'b1);
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
